magsign_checker: RTL
====================

MAGSIGN_CHECKER -- requirements
Module: magsign_checker

Interface
REQ-001 Parameter: LAT, default 1, cycles from vector issue to sampling of the sign-magnitude ALU outputs; legal range 1..7.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  vector-issue strobe; operands valid this cycle.
REQ-005 Port: Am, Bm  input  4 each  operand magnitudes.
REQ-006 Port: As, Bs  input  1 each  operand signs; 1 = negative.
REQ-007 Port: op  input  1  1 = add (A+B), 0 = subtract (A-B).
REQ-008 Port: Ym  input  4  ALU result magnitude under check.
REQ-009 Port: Ys, OF, Equal, Lessthan  input  1 each  ALU sign, overflow and compare flags under check.
REQ-010 Port: busy  output  1  vector in flight.
REQ-011 Port: done  output  1  one-cycle verdict strobe.
REQ-012 Port: pass  output  1  verdict; valid while done=1.
REQ-013 Port: mism  output  5  mismatch mask {Ym,Ys,OF,Equal,Lessthan}, bit 4 = Ym; valid while done=1.
REQ-014 Port: vec_count, err_count  output  8 each  saturating vector and failure counters.
REQ-015 Port: ff_valid  output  1  first-failure log is valid.
REQ-016 Port: ff_vec  output  11  first failing vector {As,Am,Bs,Bm,op}.

Function
REQ-017 FSM states: IDLE, WAIT, CHECK.
REQ-018 IDLE with start=1 captures As,Am,Bs,Bm,op, loads the latency counter with LAT, and moves to WAIT.
REQ-019 WAIT decrements the counter each cycle; at count 1 it registers Ym,Ys,OF,Equal,Lessthan and moves to CHECK. These are the values present in cycle T+LAT, where T is the issue cycle.
REQ-020 CHECK lasts one cycle (T+LAT+1) and drives done=1, pass and mism.
REQ-021 CHECK increments vec_count, and increments err_count when pass=0.
REQ-022 CHECK returns to IDLE; start=1 in CHECK is accepted as a new issue (back-to-back), giving one vector per LAT+1 cycles.
REQ-023 start=1 in WAIT is ignored; captured operands are unchanged.
REQ-024 busy is 1 in WAIT and CHECK, and 0 in IDLE.
REQ-025 Golden sum: S = sA*Am + sB*Bm (add) or sA*Am - sB*Bm (subtract), computed at 6-bit signed width, where sX = -1 if Xs=1, else +1.
REQ-026 Expected Ym = |S| mod 16.
REQ-027 Expected OF = 1 iff |S| > 15.
REQ-028 Expected Ys = 1 iff S < 0; a zero result always expects Ys=0.
REQ-029 Expected Equal = 1 iff the signed values of A and B are equal, with +0 equal to -0; independent of op.
REQ-030 Expected Lessthan = 1 iff signed A < signed B; independent of op.
REQ-031 mism bit = 1 where sampled differs from expected; pass = (mism == 0).
REQ-032 Outside CHECK: done=0, pass=0, mism=0.
REQ-033 vec_count and err_count hold at 255 and never wrap.

Reset
REQ-034 rst=1 forces IDLE, clears the counter and captured operands, and zeroes busy, done, pass, mism, vec_count, err_count, ff_valid and ff_vec on the next edge.
REQ-035 rst=1 in WAIT or CHECK aborts the vector: no done pulse, no counter update.
REQ-036 rst dominates start in the same cycle.

Configuration
REQ-037 Macro MAGSIGN_CHK_FIRSTFAIL_EN controls the first-failure log.
REQ-038 With MAGSIGN_CHK_FIRSTFAIL_EN defined: on the first CHECK with pass=0, capture ff_vec and set ff_valid=1; both hold until rst.
REQ-039 Without MAGSIGN_CHK_FIRSTFAIL_EN: ff_valid and ff_vec are tied to 0 and no log registers exist.

Verification
REQ-040 LAT=1; issue A=-3, B=+2, op=1; return Ym=1, Ys=1, OF=0, Equal=0, Lessthan=1 -> done at T+2, pass=1, vec_count=1, err_count=0.
REQ-041 Issue A=+14, B=+3, op=1; return Ym=1, Ys=0, OF=1, Equal=0, Lessthan=0 -> pass=1.
REQ-042 Issue A=+15, B=-15, op=0; return Ym=14, Ys=0, OF=0, Equal=0, Lessthan=0 -> pass=0, mism=5'b00100, err_count+1; with macro defined, ff_valid=1 and ff_vec={0,15,1,15,0}.
REQ-043 Issue A=+0, B=-0, op=0; return Ym=0, Ys=0, OF=0, Equal=1, Lessthan=0 -> pass=1; then return Ys=1 on the same vector -> mism=5'b01000.
REQ-044 LAT=3; issue a vector, assert rst at T+2 -> no done, vec_count=0; two back-to-back issues (second in the CHECK cycle) -> done at T+4 and T+8.
REQ-045 Issue 260 failing vectors -> err_count=255 and vec_count=255, with no wrap.

Source files
------------

// File: rtl/magsign_checker.sv
// magsign_checker
// ---------------
// Checks a 4-bit sign-magnitude ALU against a golden model. Each vector is
// issued with `start`. The ALU outputs are sampled LAT cycles after the issue.
// A one-cycle verdict follows: `done` with `pass` and `mism`.
//
// Parameters:
//   LAT       cycles from issue to sampling of the ALU outputs (1..7)
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               vector issue strobe (operands valid this cycle)
//   Am, Bm, As, Bs, op  operand magnitudes, signs (1 = negative), 1 = add
//   Ym, Ys, OF, Equal, Lessthan   ALU results under check
//   busy                vector in flight (WAIT or CHECK)
//   done, pass, mism    verdict strobe, verdict, mismatch mask {Ym,Ys,OF,Equal,Lessthan}
//   vec_count, err_count  saturating vector / failure counters
//   ff_valid, ff_vec    first-failure log {As,Am,Bs,Bm,op}
// Configuration:
//   MAGSIGN_CHK_FIRSTFAIL_EN  enables the first-failure log; otherwise ff_* are tied to 0.
module magsign_checker #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  Am,
  input  logic [3:0]  Bm,
  input  logic        As,
  input  logic        Bs,
  input  logic        op,
  input  logic [3:0]  Ym,
  input  logic        Ys,
  input  logic        OF,
  input  logic        Equal,
  input  logic        Lessthan,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  mism,
  output logic [7:0]  vec_count,
  output logic [7:0]  err_count,
  output logic        ff_valid,
  output logic [10:0] ff_vec
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CHECK = 2'd2} state_t;

  state_t      state_r, state_nx;
  logic [2:0]  cnt_r;
  logic        as_r, bs_r, op_r;
  logic [3:0]  am_r, bm_r;
  logic        busy_r, done_r, pass_r;
  logic [4:0]  mism_r;
  logic [7:0]  vec_r, err_r;
  logic        issue_s;
  logic [5:0]  a_s, b_s, sum_s, abs_s;
  logic [4:0]  mism_s;

  // Sign-magnitude operand to 6-bit two's complement (-0 maps to 0).
  function automatic logic [5:0] to_signed6(input logic sgn, input logic [3:0] mag);
    logic [5:0] ext;
    ext = {2'b00, mag};
    if (sgn) begin
      to_signed6 = 6'd0 - ext;
    end else begin
      to_signed6 = ext;
    end
  endfunction

  // A new vector is accepted from IDLE or back-to-back from CHECK.
  assign issue_s = start && ((state_r == IDLE) || (state_r == CHECK));

  // Golden result from captured operands, compared against the live ALU outputs.
  always_comb begin
    a_s   = to_signed6(as_r, am_r);
    b_s   = to_signed6(bs_r, bm_r);
    sum_s = 6'd0;
    abs_s = 6'd0;
    if (op_r) begin
      sum_s = a_s + b_s;
    end else begin
      sum_s = a_s - b_s;
    end
    if (sum_s[5]) begin
      abs_s = 6'd0 - sum_s;
    end else begin
      abs_s = sum_s;
    end
    // A zero sum has sum_s[5] = 0, so it always expects Ys = 0.
    mism_s = {(Ym != abs_s[3:0]),
              (Ys != sum_s[5]),
              (OF != (abs_s > 6'd15)),
              (Equal != (a_s == b_s)),
              (Lessthan != ($signed(a_s) < $signed(b_s)))};
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd1) begin
          state_nx = CHECK;
        end else begin
          state_nx = WAIT;
        end
      end
      CHECK: begin
        if (start) begin
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered status and verdict. The verdict is registered on the sampling edge, so it appears during CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mism_r  <= 5'd0;
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx != IDLE);
      done_r  <= (state_nx == CHECK);
      if (state_nx == CHECK) begin
        pass_r <= (mism_s == 5'd0);
        mism_r <= mism_s;
      end else begin
        pass_r <= 1'b0;
        mism_r <= 5'd0;
      end
    end
  end

  // Operand capture on issue and latency countdown while waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 3'd0;
      as_r  <= 1'b0;
      am_r  <= 4'd0;
      bs_r  <= 1'b0;
      bm_r  <= 4'd0;
      op_r  <= 1'b0;
    end else if (issue_s) begin
      cnt_r <= 3'(LAT);
      as_r  <= As;
      am_r  <= Am;
      bs_r  <= Bs;
      bm_r  <= Bm;
      op_r  <= op;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Saturating vector and failure counters, updated at the end of CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_r <= 8'd0;
      err_r <= 8'd0;
    end else if (state_r == CHECK) begin
      if (vec_r != 8'hFF) begin
        vec_r <= vec_r + 8'd1;
      end else begin
        vec_r <= vec_r;
      end
      if (!pass_r && (err_r != 8'hFF)) begin
        err_r <= err_r + 8'd1;
      end else begin
        err_r <= err_r;
      end
    end else begin
      vec_r <= vec_r;
      err_r <= err_r;
    end
  end

`ifdef MAGSIGN_CHK_FIRSTFAIL_EN
  logic        ff_valid_r;
  logic [10:0] ff_vec_r;

  // Latch the first failing vector; held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_r <= 1'b0;
      ff_vec_r   <= 11'd0;
    end else if ((state_r == CHECK) && !pass_r && !ff_valid_r) begin
      ff_valid_r <= 1'b1;
      ff_vec_r   <= {as_r, am_r, bs_r, bm_r, op_r};
    end else begin
      ff_valid_r <= ff_valid_r;
      ff_vec_r   <= ff_vec_r;
    end
  end

  assign ff_valid = ff_valid_r;
  assign ff_vec   = ff_vec_r;
`else
  assign ff_valid = 1'b0;
  assign ff_vec   = 11'd0;
`endif

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign mism      = mism_r;
  assign vec_count = vec_r;
  assign err_count = err_r;

endmodule
